// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame constants and helpers
// used by both the receiver and the transmitter.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam int unsigned UART_OVERSAMPLE = 16;
  localparam int unsigned UART_DIV_W      = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // Clocks per oversample tick for a given clock, line rate and oversampling.
  function automatic int unsigned uart_sample_div(input int unsigned clk_hz,
                                                  input int unsigned baud,
                                                  input int unsigned oversample);
    return clk_hz / (baud * oversample);
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Sample-tick generator: counts DIV-1 down to 0, ticks at 0, and can be
// re-phased with a synchronous reload.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic nrst,
  input  logic reload,
  output logic tick_c
);

  localparam logic [UART_DIV_W-1:0] RELOAD_VAL = UART_DIV_W'(DIV - 1);

  logic [UART_DIV_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q - UART_DIV_W'(1);
    if (reload || (cnt_q == '0)) begin
      cnt_d = RELOAD_VAL;
    end
  end

  // A reload in the same cycle as the terminal count restarts the phase.
  assign tick_c = (cnt_q == '0) && !reload;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchroniser, oversampled 3-sample majority vote,
// false-start rejection, framing-error strobe and early stop-bit re-arm.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 200_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
  parameter int unsigned SAMPLE_DIV = uart_sample_div(CLK_HZ, BAUD, OVERSAMPLE)
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int unsigned SAMP_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W  = $clog2(UART_DATA_BITS);

  localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(OVERSAMPLE - 1);
  localparam logic [SAMP_W-1:0] VOTE_A    = SAMP_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SAMP_W-1:0] VOTE_B    = SAMP_W'(OVERSAMPLE / 2);
  localparam logic [SAMP_W-1:0] VOTE_MID  = SAMP_W'(OVERSAMPLE / 2 + 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(UART_DATA_BITS - 1);

  uart_state_e                state_q, state_d;
  logic [1:0]                 sync_q, sync_d;
  logic                       rxd_prev_q, rxd_prev_d;
  logic [SAMP_W-1:0]          samp_q, samp_d;
  logic [BIT_W-1:0]           bit_q, bit_d;
  logic [1:0]                 vote_q, vote_d;
  logic [UART_DATA_BITS-1:0]  shift_q, shift_d;
  logic [UART_DATA_BITS-1:0]  data_q, data_d;
  logic                       done_q, done_d;
  logic                       ferr_q, ferr_d;
  logic                       busy_q, busy_d;

  logic rxd_s;
  logic tick_c;
  logic reload_c;
  logic mid_c;
  logic vote_c;

  assign rxd_s = sync_q[1];

  uart_baud_tick #(
    .DIV (SAMPLE_DIV)
  ) u_tick (
    .clk    (clk),
    .nrst   (nrst),
    .reload (reload_c),
    .tick_c (tick_c)
  );

  assign mid_c  = tick_c && (samp_q == VOTE_MID);
  assign vote_c = majority3(vote_q[0], vote_q[1], rxd_s);

  always_comb begin
    state_d    = state_q;
    sync_d     = {sync_q[0], rxd};
    rxd_prev_d = rxd_s;
    samp_d     = samp_q;
    bit_d      = bit_q;
    vote_d     = vote_q;
    shift_d    = shift_q;
    data_d     = data_q;
    done_d     = 1'b0;
    ferr_d     = 1'b0;
    busy_d     = busy_q;
    reload_c   = 1'b0;

    // Oversample position within the current bit, plus the two early votes.
    if (tick_c) begin
      samp_d = (samp_q == SAMP_LAST) ? '0 : samp_q + SAMP_W'(1);
      if (samp_q == VOTE_A) vote_d[0] = rxd_s;
      if (samp_q == VOTE_B) vote_d[1] = rxd_s;
    end

    unique case (state_q)
      IDLE: begin
        if (rxd_prev_q && !rxd_s) begin
          state_d  = START;
          busy_d   = 1'b1;
          reload_c = 1'b1;
          samp_d   = '0;
        end
      end
      START: begin
        if (mid_c) begin
          if (!vote_c) begin
            state_d = DATA;
            bit_d   = '0;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      DATA: begin
        if (mid_c) begin
          shift_d = {vote_c, shift_q[UART_DATA_BITS-1:1]};
          bit_d   = bit_q + BIT_W'(1);
          if (bit_q == BIT_LAST) state_d = STOP;
        end
      end
      STOP: begin
        // Re-arm at the stop-bit centre so a back-to-back start edge is caught.
        if (mid_c) begin
          data_d  = shift_q;
          done_d  = vote_c;
          ferr_d  = !vote_c;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      sync_q     <= 2'b11;
      rxd_prev_q <= 1'b1;
      samp_q     <= '0;
      bit_q      <= '0;
      vote_q     <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      rxd_prev_q <= rxd_prev_d;
      samp_q     <= samp_d;
      bit_q      <= bit_d;
      vote_q     <= vote_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
      busy_q     <= busy_d;
    end
  end

  assign rx_data      = data_q;
  assign rx_done      = done_q;
  assign rx_frame_err = ferr_q;
  assign rx_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a behavioural line driver plays the
// transmitter, and received bytes are compared against a queue of sent bytes.
module tb_uart_rx;

  localparam int unsigned CLK_HZ   = 3_200_000;
  localparam int unsigned BAUD     = 100_000;
  localparam int unsigned OS       = 16;
  localparam int unsigned DIV      = 2;
  localparam int          BIT_CLKS = CLK_HZ / BAUD;
  // Line fall to strobe: sync + 9 bit times + (OS/2+2) ticks; +1 for the output flop.
  localparam int          EXP_LAT  = 2 + 9 * BIT_CLKS + (OS / 2 + 2) * DIV + 1;

  logic       clk = 1'b0;
  logic       nrst;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_frame_err;
  logic       rx_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int         done_cnt = 0;
  int         ferr_cnt = 0;
  int         both_cnt = 0;
  int         busy_rise = 0;
  logic       busy_prev = 1'b0;
  logic [7:0] ferr_data = 8'h00;
  int         last_done_cyc = 0;
  int         fall_cyc = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  uart_rx #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OS),
    .SAMPLE_DIV (DIV)
  ) dut (
    .clk          (clk),
    .nrst         (nrst),
    .rxd          (rxd),
    .rx_data      (rx_data),
    .rx_done      (rx_done),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy)
  );

  // Output monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (rx_done) begin
      done_cnt++;
      got_q.push_back(rx_data);
      last_done_cyc = cyc;
    end
    if (rx_frame_err) begin
      ferr_cnt++;
      ferr_data = rx_data;
    end
    if (rx_done && rx_frame_err) both_cnt++;
    if (rx_busy && !busy_prev) busy_rise++;
    busy_prev = rx_busy;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no end of test, required finish before timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drives nbits of an 8N1 frame; optional 2-clock inversion at each start/data bit centre.
  task automatic send_frame(input logic [7:0] data, input logic stop_val,
                            input int bit_clks, input bit glitch, input int nbits);
    logic [9:0] frame;
    frame = {stop_val, data, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      for (int c = 0; c < bit_clks; c++) begin
        if (i == 0 && c == 0) fall_cyc = cyc;
        if (glitch && i < 9 && (c == bit_clks / 2 || c == bit_clks / 2 + 1))
          rxd = ~frame[i];
        else
          rxd = frame[i];
        @(negedge clk);
      end
    end
  endtask

  task automatic wait_strobes(input int target);
    for (int k = 0; k < 2000; k++) begin
      if (done_cnt + ferr_cnt >= target) break;
      @(negedge clk);
    end
    chk("strobe_wait", 32'(done_cnt + ferr_cnt), 32'(target));
  endtask

  task automatic check_bytes(input string tag);
    int n;
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_byte"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int lat;
    int br;
    int d0;
    int f0;
    int baud_clks[3];
    baud_clks[0] = BIT_CLKS;
    baud_clks[1] = BIT_CLKS - 1;
    baud_clks[2] = BIT_CLKS + 1;

    nrst = 1'b0;
    rxd  = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_data", 32'(rx_data), 32'h0);
    chk("reset_done", 32'(rx_done), 32'h0);
    chk("reset_ferr", 32'(rx_frame_err), 32'h0);
    chk("reset_busy", 32'(rx_busy), 32'h0);
    nrst = 1'b1;
    idle(40);

    // Single frame, latency and idle state afterwards.
    send_frame(8'hA5, 1'b1, BIT_CLKS, 1'b0, 10);
    exp_q.push_back(8'hA5);
    idle(32);
    wait_strobes(1);
    lat = last_done_cyc - fall_cyc;
    chk("t1_done_cnt", 32'(done_cnt), 32'd1);
    chk("t1_latency", 32'(lat >= EXP_LAT - int'(DIV) && lat <= EXP_LAT + int'(DIV)), 32'd1);
    chk("t1_ferr_cnt", 32'(ferr_cnt), 32'd0);
    chk("t1_busy", 32'(rx_busy), 32'd0);
    chk("t1_rx_data", 32'(rx_data), 32'hA5);
    check_bytes("t1");

    // Back-to-back frames, no idle gap.
    send_frame(8'h00, 1'b1, BIT_CLKS, 1'b0, 10);
    send_frame(8'hFF, 1'b1, BIT_CLKS, 1'b0, 10);
    send_frame(8'h55, 1'b1, BIT_CLKS, 1'b0, 10);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h55);
    idle(32);
    wait_strobes(4);
    chk("t2_done_cnt", 32'(done_cnt), 32'd4);
    check_bytes("t2");

    // Short low pulse: busy blip, no strobe.
    br = busy_rise;
    rxd = 1'b0;
    repeat (3 * DIV) @(negedge clk);
    idle(80);
    chk("t3_busy_pulse", 32'(busy_rise), 32'(br + 1));
    chk("t3_no_strobe", 32'(done_cnt + ferr_cnt), 32'd4);
    chk("t3_busy_low", 32'(rx_busy), 32'd0);
    send_frame(8'h3C, 1'b1, BIT_CLKS, 1'b0, 10);
    exp_q.push_back(8'h3C);
    idle(32);
    wait_strobes(5);
    check_bytes("t3");

    // Framing error followed by a long break, then recovery.
    send_frame(8'h3C, 1'b0, BIT_CLKS, 1'b0, 10);
    br = busy_rise;
    rxd = 1'b0;
    repeat (20 * BIT_CLKS) @(negedge clk);
    chk("t4_ferr_cnt", 32'(ferr_cnt), 32'd1);
    chk("t4_no_done", 32'(done_cnt), 32'd5);
    chk("t4_ferr_data", 32'(ferr_data), 32'h3C);
    chk("t4_rx_data", 32'(rx_data), 32'h3C);
    chk("t4_no_restart", 32'(busy_rise), 32'(br));
    chk("t4_busy_low", 32'(rx_busy), 32'd0);
    idle(2 * BIT_CLKS);
    send_frame(8'h81, 1'b1, BIT_CLKS, 1'b0, 10);
    exp_q.push_back(8'h81);
    idle(32);
    wait_strobes(7);
    check_bytes("t4");
    chk("t4_ferr_stable", 32'(ferr_cnt), 32'd1);

    // Glitched bit centres at nominal, fast and slow line rates, plus random bytes.
    for (int r = 0; r < 3; r++) begin
      d0 = done_cnt;
      send_frame(8'h69, 1'b1, baud_clks[r], 1'b1, 10);
      exp_q.push_back(8'h69);
      idle(40);
      wait_strobes(d0 + ferr_cnt + 1);
      check_bytes("t5");
    end
    for (int r = 0; r < 4; r++) begin
      logic [7:0] b;
      b = 8'($urandom);
      d0 = done_cnt;
      send_frame(b, 1'b1, baud_clks[$urandom_range(0, 2)], 1'b0, 10);
      exp_q.push_back(b);
      idle(20);
      wait_strobes(d0 + ferr_cnt + 1);
      check_bytes("t5_rand");
    end

    // Reset in the middle of the data bits.
    send_frame(8'hF0, 1'b1, BIT_CLKS, 1'b0, 5);
    chk("t6_busy_pre", 32'(rx_busy), 32'd1);
    nrst = 1'b0;
    #1;
    chk("t6_rst_data", 32'(rx_data), 32'h0);
    chk("t6_rst_busy", 32'(rx_busy), 32'd0);
    chk("t6_rst_done", 32'(rx_done), 32'd0);
    chk("t6_rst_ferr", 32'(rx_frame_err), 32'd0);
    rxd = 1'b1;
    repeat (4) @(negedge clk);
    nrst = 1'b1;
    d0 = done_cnt;
    f0 = ferr_cnt;
    idle(2 * BIT_CLKS);
    chk("t6_no_spurious", 32'(done_cnt + ferr_cnt), 32'(d0 + f0));
    send_frame(8'h0F, 1'b1, BIT_CLKS, 1'b0, 10);
    exp_q.push_back(8'h0F);
    idle(40);
    wait_strobes(d0 + f0 + 1);
    chk("t6_done_cnt", 32'(done_cnt), 32'(d0 + 1));
    chk("t6_ferr_cnt", 32'(ferr_cnt), 32'(f0));
    check_bytes("t6");

    chk("never_both", 32'(both_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
